// File: rtl/vs_dict_proc_pkg.sv
// vs_dict_proc_pkg: shared sizes, command/state types and fixed-point narrowing for the dictionary processor.
// Optional macro VS_DICT_PROC_SATURATE_EN: narrowing saturates to the 32-bit signed range instead of wrapping.
package vs_dict_proc_pkg;
    localparam int SIGNAL_SIZE_DEFAULT     = 16;
    localparam int DICTIONARY_SIZE_DEFAULT = 64;
    localparam int FP_Q_DEFAULT            = 15;
    localparam int VS_DICT_ACC_WIDTH       = 72;

    typedef enum logic [1:0] {
        CMD_NOP                    = 2'd0,
        CMD_LOAD_SENSING_MATRIX    = 2'd1,
        CMD_COMPUTE_INNER_PRODUCTS = 2'd2,
        CMD_COMPUTE_APPROXIMATION  = 2'd3
    } vs_dict_proc_command_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD, ST_IP_RUN, ST_IP_DRAIN, ST_IP_OUT,
        ST_AP_RUN, ST_AP_DRAIN, ST_AP_WR, ST_DONE
    } vs_dict_proc_state_t;

    // Reduce an already-shifted accumulator to a 32-bit Q15 word.
    function automatic logic [31:0] vs_fixed_narrow(input logic [VS_DICT_ACC_WIDTH-1:0] acc);
`ifdef VS_DICT_PROC_SATURATE_EN
        // In range only when every bit above bit 31 matches the sign.
        return (&acc[VS_DICT_ACC_WIDTH-1:31] || ~|acc[VS_DICT_ACC_WIDTH-1:31]) ? acc[31:0] :
               (acc[VS_DICT_ACC_WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);
`else
        return acc[31:0];
`endif
    endfunction
endpackage

// File: rtl/vs_fp_mac.sv
// vs_fp_mac: signed 32x32 multiply-accumulate into a 72-bit accumulator with Q-shifted, narrowed output.
// Ports: clk, reset (sync, active-high); clear restarts the sum with the current product; en adds a*b;
//        result = narrow(acc >>> FP_Q). Narrowing mode follows VS_DICT_PROC_SATURATE_EN.
module vs_fp_mac
    import vs_dict_proc_pkg::*;
#(
    parameter int FP_Q = FP_Q_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    logic signed [63:0]                  prod;
    logic signed [VS_DICT_ACC_WIDTH-1:0] prod_ext, acc, shifted;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(VS_DICT_ACC_WIDTH-64){prod[63]}}, prod};
    assign shifted  = acc >>> FP_Q;
    assign result   = vs_fixed_narrow(shifted);

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (en)
            acc <= clear ? prod_ext : acc + prod_ext;
    end
endmodule

// File: rtl/vs_dict_proc.sv
// vs_dict_proc: command responder owning dictionary traffic (matrix load, D^T r, D x).
// Ports: clk/reset (sync, active-high); cmd_valid/cmd/cmd_ready command handshake; busy, done pulse;
//        load_valid/load_data/load_ready matrix stream; dict_* dictionary RAM; sig_* residual read and
//        approximation write; x_* representation read; ip_valid/ip_index/ip_data/ip_ready result stream.
// Optional macro VS_DICT_PROC_SATURATE_EN: saturating instead of wrapping result narrowing.
module vs_dict_proc
    import vs_dict_proc_pkg::*;
#(
    parameter int M    = SIGNAL_SIZE_DEFAULT,
    parameter int N    = DICTIONARY_SIZE_DEFAULT,
    parameter int FP_Q = FP_Q_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  vs_dict_proc_command_t cmd,
    output logic                  cmd_ready,
    output logic                  busy,
    output logic                  done,
    input  logic                  load_valid,
    input  logic [31:0]           load_data,
    output logic                  load_ready,
    output logic                  dict_we,
    output logic [15:0]           dict_waddr,
    output logic [31:0]           dict_wdata,
    output logic [15:0]           dict_raddr,
    input  logic [31:0]           dict_rdata,
    output logic [7:0]            sig_raddr,
    input  logic [31:0]           sig_rdata,
    output logic                  sig_we,
    output logic [7:0]            sig_waddr,
    output logic [31:0]           sig_wdata,
    output logic [7:0]            x_raddr,
    input  logic [31:0]           x_rdata,
    output logic                  ip_valid,
    output logic [7:0]            ip_index,
    output logic [31:0]           ip_data,
    input  logic                  ip_ready
);
    localparam int MN = M * N;

    vs_dict_proc_state_t state, state_n;
    logic [7:0]  i, i_n, j, j_n;
    logic [15:0] k, k_n;
    logic        mac_en, mac_clr;
    logic [31:0] result;

    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        k_n     = k;
        case (state)
            ST_IDLE: if (cmd_valid) begin
                i_n     = '0;
                j_n     = '0;
                k_n     = (cmd == CMD_LOAD_SENSING_MATRIX) ? '0 : k;
                state_n = (cmd == CMD_LOAD_SENSING_MATRIX)    ? ST_LOAD   :
                          (cmd == CMD_COMPUTE_INNER_PRODUCTS) ? ST_IP_RUN :
                          (cmd == CMD_COMPUTE_APPROXIMATION)  ? ST_AP_RUN : ST_DONE;
            end
            ST_LOAD: if (load_valid) begin
                if (k == 16'(MN - 1)) state_n = ST_DONE;
                else k_n = k + 16'd1;
            end
            ST_IP_RUN: if (i == 8'(M - 1)) state_n = ST_IP_DRAIN;
                       else i_n = i + 8'd1;
            ST_IP_DRAIN: state_n = ST_IP_OUT;
            ST_IP_OUT: if (ip_ready) begin
                if (j == 8'(N - 1)) state_n = ST_DONE;
                else begin
                    state_n = ST_IP_RUN;
                    i_n     = '0;
                    j_n     = j + 8'd1;
                end
            end
            ST_AP_RUN: if (j == 8'(N - 1)) state_n = ST_AP_DRAIN;
                       else j_n = j + 8'd1;
            ST_AP_DRAIN: state_n = ST_AP_WR;
            ST_AP_WR: if (i == 8'(M - 1)) state_n = ST_DONE;
                else begin
                    state_n = ST_AP_RUN;
                    i_n     = i + 8'd1;
                    j_n     = '0;
                end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Read addresses are registered from the next-state counters so they are valid during
    // the RUN cycle that owns them and hold their last value otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            dict_raddr <= '0;
            sig_raddr  <= '0;
            x_raddr    <= '0;
            sig_waddr  <= '0;
            mac_en     <= 1'b0;
            mac_clr    <= 1'b0;
        end else begin
            state <= state_n;
            i     <= i_n;
            j     <= j_n;
            k     <= k_n;
            if (state_n == ST_IP_RUN || state_n == ST_AP_RUN)
                dict_raddr <= 16'(32'(j_n) * M + 32'(i_n));
            if (state_n == ST_IP_RUN) sig_raddr <= i_n;
            if (state_n == ST_AP_RUN) x_raddr <= j_n;
            if (state_n == ST_AP_WR) sig_waddr <= i;
            // RAM data lags the address by one cycle, so the MAC controls do too.
            mac_en  <= (state == ST_IP_RUN) || (state == ST_AP_RUN);
            mac_clr <= (state == ST_IP_RUN && i == '0) || (state == ST_AP_RUN && j == '0);
        end
    end

    vs_fp_mac #(.FP_Q(FP_Q)) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (mac_clr),
        .en     (mac_en),
        .a      (dict_rdata),
        .b      ((state == ST_AP_RUN || state == ST_AP_DRAIN) ? x_rdata : sig_rdata),
        .result (result)
    );

    assign cmd_ready  = state == ST_IDLE;
    assign busy       = state != ST_IDLE;
    assign done       = state == ST_DONE;
    assign load_ready = state == ST_LOAD;
    assign dict_we    = load_ready && load_valid;
    assign dict_waddr = k;
    assign dict_wdata = load_ready ? load_data : '0;
    assign sig_we     = state == ST_AP_WR;
    assign sig_wdata  = sig_we ? result : '0;
    assign ip_valid   = state == ST_IP_OUT;
    assign ip_index   = ip_valid ? j : '0;
    assign ip_data    = ip_valid ? result : '0;
endmodule

// File: tb/tb_vs_dict_proc.sv
// tb_vs_dict_proc: self-checking bench for vs_dict_proc with behavioural RAMs and queue scoreboards.
module tb_vs_dict_proc;
    import vs_dict_proc_pkg::*;

    localparam int M  = 16;
    localparam int N  = 64;
    localparam int MN = M * N;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                  cmd_valid = 1'b0;
    vs_dict_proc_command_t cmd = CMD_NOP;
    logic                  cmd_ready, busy, done;
    logic                  load_valid = 1'b0;
    logic [31:0]           load_data = '0;
    logic                  load_ready, dict_we;
    logic [15:0]           dict_waddr, dict_raddr;
    logic [31:0]           dict_wdata, dict_rdata, sig_rdata, x_rdata, sig_wdata, ip_data;
    logic [7:0]            sig_raddr, sig_waddr, x_raddr, ip_index;
    logic                  sig_we, ip_valid;
    logic                  ip_ready = 1'b0;

    logic [31:0] dict_mem [MN];
    logic [31:0] d_model  [MN];
    logic [31:0] sig_mem  [256];
    logic [31:0] x_mem    [256];

    int checks = 0;
    int fails  = 0;

    vs_dict_proc dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .busy(busy), .done(done), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .dict_we(dict_we), .dict_waddr(dict_waddr),
        .dict_wdata(dict_wdata), .dict_raddr(dict_raddr), .dict_rdata(dict_rdata),
        .sig_raddr(sig_raddr), .sig_rdata(sig_rdata), .sig_we(sig_we), .sig_waddr(sig_waddr),
        .sig_wdata(sig_wdata), .x_raddr(x_raddr), .x_rdata(x_rdata), .ip_valid(ip_valid),
        .ip_index(ip_index), .ip_data(ip_data), .ip_ready(ip_ready)
    );

    // Synchronous RAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (dict_we) dict_mem[dict_waddr[9:0]] <= dict_wdata;
        dict_rdata <= dict_mem[dict_raddr[9:0]];
        sig_rdata  <= sig_mem[sig_raddr];
        x_rdata    <= x_mem[x_raddr];
    end

    function automatic logic [31:0] narrow(input logic signed [71:0] s);
`ifdef VS_DICT_PROC_SATURATE_EN
        if (s > 72'sh7FFFFFFF) return 32'h7FFF_FFFF;
        if (s < -72'sh80000000) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] model_ip(input int j);
        logic signed [71:0] acc, a, b;
        acc = '0;
        for (int i = 0; i < M; i++) begin
            a = $signed(d_model[j*M + i]);
            b = $signed(sig_mem[i]);
            acc += a * b;
        end
        return narrow(acc >>> 15);
    endfunction

    function automatic logic [31:0] model_ap(input int i);
        logic signed [71:0] acc, a, b;
        acc = '0;
        for (int j = 0; j < N; j++) begin
            a = $signed(d_model[j*M + i]);
            b = $signed(x_mem[j]);
            acc += a * b;
        end
        return narrow(acc >>> 15);
    endfunction

    task automatic issue(input vs_dict_proc_command_t c);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = CMD_NOP;
    endtask

    // mode 1: D[i,j] = 0x4000 (0.5 in Q15) where i == j%16; mode 2: all 0x7FFFFFFF.
    task automatic load_matrix(input int mode);
        int k = 0;
        for (int q = 0; q < MN; q++)
            d_model[q] = (mode == 1) ? (((q % M) == ((q / M) % 16)) ? 32'h4000 : 32'h0) : 32'h7FFF_FFFF;
        issue(CMD_LOAD_SENSING_MATRIX);
        for (int c = 0; c < 8*MN && k < MN; c++) begin
            @(negedge clk);
            load_valid = $urandom_range(0, 1) != 0;
            load_data  = d_model[k];
            if (load_valid) k++;
        end
        @(negedge clk);
        load_valid = 1'b0;
        #1;
        checks++;
        if (k != MN || done !== 1'b1) begin
            fails++;
            $display("FAIL load_matrix beats=%0d done=%b, want %0d and 1", k, done, MN);
        end
    endtask

    task automatic run_ip(input int stall, input string tag);
        logic [7:0]  exp_idx [$];
        logic [31:0] exp_dat [$];
        logic [7:0]  h_idx;
        logic [31:0] h_dat;
        int got = 0, wait_n = 0, dones = 0;
        for (int j = 0; j < N; j++) begin
            exp_idx.push_back(8'(j));
            exp_dat.push_back(model_ip(j));
        end
        issue(CMD_COMPUTE_INNER_PRODUCTS);
        for (int c = 0; c < 20000 && got < N; c++) begin
            @(negedge clk);
            ip_ready = wait_n >= stall;
            #1;
            if (done) dones++;
            if (ip_valid) begin
                if (wait_n == 0) begin
                    h_idx = exp_idx.pop_front();
                    h_dat = exp_dat.pop_front();
                end
                checks += 2;
                if (ip_index !== h_idx) begin
                    fails++;
                    $display("FAIL %s ip_index got %0d want %0d (stall cycle %0d)", tag, ip_index, h_idx, wait_n);
                end
                if (ip_data !== h_dat) begin
                    fails++;
                    $display("FAIL %s ip_data[%0d] got %h want %h (stall cycle %0d)", tag, h_idx, ip_data, h_dat, wait_n);
                end
                if (ip_ready) begin
                    got++;
                    wait_n = 0;
                end else wait_n++;
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ip_ready = 1'b0;
            #1;
            if (done) dones++;
            if (ip_valid) got++;
        end
        checks += 3;
        if (got != N) begin
            fails++;
            $display("FAIL %s output count got %0d want %0d", tag, got, N);
        end
        if (dones != 1) begin
            fails++;
            $display("FAIL %s done pulses got %0d want 1", tag, dones);
        end
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s cmd_ready got %b want 1", tag, cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks += 2;
        if ({busy, done, load_ready, dict_we, dict_waddr, dict_wdata, dict_raddr, sig_raddr, sig_we,
             sig_waddr, sig_wdata, x_raddr, ip_valid, ip_index, ip_data} !== '0) begin
            fails++;
            $display("FAIL reset outputs not all zero: busy=%b done=%b ip_valid=%b dict_raddr=%h", busy, done, ip_valid, dict_raddr);
        end
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset cmd_ready got %b want 1", cmd_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_load();
        logic [15:0] exp_q [$];
        logic [15:0] e;
        int k = 0, wes = 0, dones = 0, extra = 0;
        for (int q = 0; q < MN; q++) d_model[q] = 32'(q);
        issue(CMD_LOAD_SENSING_MATRIX);
        for (int c = 0; c < 8*MN && k < MN; c++) begin
            @(negedge clk);
            load_valid = $urandom_range(0, 3) != 0;
            load_data  = d_model[k];
            if (load_valid) begin
                exp_q.push_back(16'(k));
                k++;
            end
            #1;
            checks += 2;
            if (load_ready !== 1'b1) begin
                fails++;
                $display("FAIL load load_ready got %b want 1 at beat %0d", load_ready, k);
            end
            if (dict_we !== load_valid) begin
                fails++;
                $display("FAIL load dict_we got %b want %b at beat %0d", dict_we, load_valid, k);
            end
            if (dict_we === 1'b1 && exp_q.size() != 0) begin
                wes++;
                e = exp_q.pop_front();
                checks += 2;
                if (dict_waddr !== e) begin
                    fails++;
                    $display("FAIL load dict_waddr got %h want %h", dict_waddr, e);
                end
                if (dict_wdata !== {16'h0, e}) begin
                    fails++;
                    $display("FAIL load dict_wdata got %h want %h", dict_wdata, {16'h0, e});
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            load_valid = 1'b1;
            #1;
            if (done) dones++;
            if (dict_we) extra++;
        end
        load_valid = 1'b0;
        checks += 4;
        if (wes != MN) begin
            fails++;
            $display("FAIL load dict_we count got %0d want %0d", wes, MN);
        end
        if (extra != 0) begin
            fails++;
            $display("FAIL load writes after last beat got %0d want 0", extra);
        end
        if (dones != 1) begin
            fails++;
            $display("FAIL load done pulses got %0d want 1", dones);
        end
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL load cmd_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_inner_products();
        load_matrix(1);
        for (int i = 0; i < 256; i++) sig_mem[i] = 32'(i) * 32'h8000;
        checks++;
        if (model_ip(3) !== 32'h0000_C000 || model_ip(19) !== 32'h0000_C000) begin
            fails++;
            $display("FAIL ip_model ip[3]=%h ip[19]=%h want 0000c000", model_ip(3), model_ip(19));
        end
        run_ip(0, "ip");
    endtask

    task automatic test_backpressure();
        run_ip(5, "ip_stall");
    endtask

    task automatic test_approximation();
        logic [31:0] exp_q [$];
        logic [31:0] e;
        int wes = 0, dones = 0;
        for (int j = 0; j < 256; j++) x_mem[j] = (j == 5) ? 32'h8000 : 32'h0;
        for (int i = 0; i < M; i++) exp_q.push_back(model_ap(i));
        issue(CMD_COMPUTE_APPROXIMATION);
        for (int c = 0; c < 5000 && dones == 0; c++) begin
            @(negedge clk);
            #1;
            if (done) dones++;
            if (sig_we === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks += 2;
                if (sig_waddr !== 8'(wes)) begin
                    fails++;
                    $display("FAIL approx sig_waddr got %0d want %0d", sig_waddr, wes);
                end
                if (sig_wdata !== e) begin
                    fails++;
                    $display("FAIL approx y_hat[%0d] got %h want %h", wes, sig_wdata, e);
                end
                wes++;
            end
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done) dones++;
            if (sig_we) wes++;
        end
        checks += 2;
        if (wes != M) begin
            fails++;
            $display("FAIL approx sig_we count got %0d want %0d", wes, M);
        end
        if (dones != 1) begin
            fails++;
            $display("FAIL approx done pulses got %0d want 1", dones);
        end
    endtask

    task automatic test_overflow();
        load_matrix(2);
        for (int i = 0; i < 256; i++) sig_mem[i] = 32'h7FFF_FFFF;
        run_ip(0, "ovf_pos");
        for (int i = 0; i < 256; i++) sig_mem[i] = 32'h8000_0000;
        run_ip(0, "ovf_neg");
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        bit hit = 0;
        issue(CMD_COMPUTE_INNER_PRODUCTS);
        for (int c = 0; c < 5000 && !hit; c++) begin
            @(negedge clk);
            ip_ready = 1'b1;
            #1;
            hit = ip_valid === 1'b1 && ip_index === 8'd10;
        end
        checks++;
        if (!hit) begin
            fails++;
            $display("FAIL reset_mid column 10 never reached");
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks += 2;
        if ({busy, done, load_ready, dict_we, dict_waddr, dict_wdata, dict_raddr, sig_raddr, sig_we,
             sig_waddr, sig_wdata, x_raddr, ip_valid, ip_index, ip_data} !== '0) begin
            fails++;
            $display("FAIL reset_mid outputs not zero: busy=%b ip_valid=%b ip_index=%0d dict_raddr=%h", busy, ip_valid, ip_index, dict_raddr);
        end
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid cmd_ready got %b want 1", cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        ip_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            fails++;
            $display("FAIL reset_mid done pulses after abort got %0d want 0", dones);
        end
        run_ip(0, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sig_mem[i] = '0;
            x_mem[i]   = '0;
        end
        test_reset();
        test_load();
        test_inner_products();
        test_backpressure();
        test_approximation();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
